lector_de_registros: RTL

Sequential read-out engine for the register bank. On a start pulse it sweeps the bank's `addr_rs1` read port over an inclusive address range and streams each word out over a valid/ready handshake, one word per cycle when not back-pressured. It sits between `banco_de_registros` and any debug or dump consumer, such as a UART transmitter or a test monitor.

---
 rtl/lector_de_registros.sv | 138 +++++++++++++
 1 files changed

// File: rtl/lector_de_registros.sv
// lector_de_registros: sweeps the register bank read port over an inclusive,
// wrapping address range and streams each word over a valid/ready handshake.
//
// Handshake: a word transfers on any rising edge where out_valid and out_ready
// are both 1. out_data/out_addr stay stable while out_valid=1 and out_ready=0.
// out_valid never drops without a transfer, except on abort or reset.
module lector_de_registros #(
  parameter int N = 5,
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] addr_lo,
  input  logic [N-1:0] addr_hi,
  output logic [N-1:0] addr_rs1,
  input  logic [M-1:0] rs1,
  output logic [M-1:0] out_data,
  output logic [N-1:0] out_addr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   ptr_q, ptr_d;
  logic [N-1:0]   last_q, last_d;
  logic           fin_q, fin_d;
  logic [M-1:0]   data_q, data_d;
  logic [N-1:0]   oaddr_q, oaddr_d;
  logic           valid_q, valid_d;
  logic           load;

  // Next-state logic: sequencing, range latch and word loading from the bank.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    fin_d   = fin_q;
    data_d  = data_q;
    oaddr_d = oaddr_q;
    valid_d = valid_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = addr_lo;
          last_d  = addr_hi;
          fin_d   = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // Abort wins over a handshake in the same cycle.
        if (abort) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (valid_q && out_ready) begin
          if (fin_q) begin
            valid_d = 1'b0;
            state_d = DONE;
          end else begin
            load = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Capture the word at ptr; the pointer stops at the end address and the
    // fin flag marks that the final word is now in the output register.
    if (load) begin
      data_d  = rs1;
      oaddr_d = ptr_q;
      valid_d = 1'b1;
      if (ptr_q == last_q) begin
        fin_d = 1'b1;
      end else begin
        ptr_d = ptr_q + N'(1);
      end
    end
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      fin_q   <= 1'b0;
      data_q  <= '0;
      oaddr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      fin_q   <= fin_d;
      data_q  <= data_d;
      oaddr_q <= oaddr_d;
      valid_q <= valid_d;
    end
  end

  assign addr_rs1  = ptr_q;
  assign out_data  = data_q;
  assign out_addr  = oaddr_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule
